fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the mock memory's read-only port B (`addrB`/`dataB_o`). It holds the PC, issues one word address per cycle into the memory's one-cycle registered read port, and captures each returned word with its PC into a small FIFO. It presents instructions to decode over a valid/ready handshake and accepts redirects from execute (branches and jumps), flushing all stale work.

---
 rtl/fetch_unit.sv | 83 ++++++++
 tb/tb_fetch_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: PC + one-cycle memory fetch into a small {pc, word} FIFO with redirect flush.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirects halt fetch and raise sticky misaligned.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        misaligned
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [AW+1:0] DEPTH = (AW+2)'(BUF_DEPTH);
  logic [31:0] pc_q, inflight_pc_q;
  logic inflight_q, halted, pop, push, issue;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic [AW+1:0] occ;
  logic [31:0] buf_pc [BUF_DEPTH];
  logic [31:0] buf_data [BUF_DEPTH];
  logic [31:0] pc_mask;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic flag_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) flag_q <= 1'b0;
    else if (redirect_valid) flag_q <= |redirect_pc[1:0];
  assign halted     = flag_q;
  assign misaligned = flag_q;
  assign pc_mask    = 32'hFFFF_FFFF;
`else
  assign halted     = 1'b0;
  assign misaligned = 1'b0;
  assign pc_mask    = 32'hFFFF_FFFC;
`endif
  assign imem_addr   = pc_q;
  assign instr_valid = count != '0;
  assign instr_data  = buf_data[rd_ptr];
  assign instr_pc    = buf_pc[rd_ptr];
  assign pop         = instr_valid & instr_ready;
  assign push        = inflight_q & !redirect_valid;
  // Occupancy counts the word still in flight so a slot is always reserved for it.
  assign occ         = (AW+2)'(count) + (AW+2)'(inflight_q) - (AW+2)'(pop);
  assign issue       = !redirect_valid & !halted & (occ < DEPTH);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_pc[i]   <= '0;
        buf_data[i] <= '0;
      end
    end else if (redirect_valid) begin
      pc_q       <= redirect_pc & pc_mask;
      inflight_q <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else begin
      if (issue) begin
        pc_q          <= pc_q + 32'd4;
        inflight_pc_q <= pc_q;
      end
      inflight_q <= issue;
      if (push) begin
        buf_pc[wr_ptr]   <= inflight_pc_q;
        buf_data[wr_ptr] <= imem_data;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit against an in-order PC stream model.
module tb_fetch_unit;
  logic clk = 0, rst_n = 0;
  logic [31:0] imem_addr, imem_data, redirect_pc, instr_data, instr_pc;
  logic redirect_valid = 0, instr_valid, instr_ready = 0, misaligned;
  int tests = 0, fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] gen_pc = 32'h100;
  bit halted_m = 0;
  bit prev_stall = 0;
  logic [31:0] prev_pc, prev_data;

  fetch_unit #(.RESET_PC(32'h100), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc), .misaligned(misaligned));

  always #5 clk = ~clk;
  // Memory holds word == byte address, one-cycle registered read.
  always @(posedge clk) imem_data <= imem_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Each stimulus cycle extends the expected in-order stream by one PC.
  task automatic tick();
    @(posedge clk); #1;
    if (!halted_m) begin
      exp_q.push_back(gen_pc);
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  task automatic model_restart(input logic [31:0] start);
    exp_q.delete();
    gen_pc = start;
    halted_m = 0;
  endtask

  task automatic redirect(input logic [31:0] t);
    redirect_valid = 1;
    redirect_pc = t;
`ifdef FETCH_MISALIGN_CHECK_EN
    model_restart(t);
    halted_m = (t[1:0] != 2'b00);
`else
    model_restart({t[31:2], 2'b00});
`endif
    tick();
    redirect_valid = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 32'(instr_valid), 0);
    chk({tag, "_addr"}, imem_addr, 32'h100);
    chk({tag, "_data"}, instr_data, 0);
    chk({tag, "_pc"}, instr_pc, 0);
    chk({tag, "_mis"}, 32'(misaligned), 0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) prev_stall = 0;
    else begin
      if (prev_stall) begin
        chk("hold_pc", instr_pc, prev_pc);
        chk("hold_data", instr_data, prev_data);
      end
      if (instr_valid && instr_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_instr: got pc %h with empty expected queue", instr_pc);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          chk("stream_pc", instr_pc, e);
          chk("stream_data", instr_data, e);
        end
      end
      prev_stall = instr_valid && !instr_ready && !redirect_valid;
      prev_pc = instr_pc;
      prev_data = instr_data;
    end
  end

  initial begin
    logic [31:0] t;
    redirect_pc = 0;
    // Reset values and first-fetch latency
    instr_ready = 1;
    tick(); tick();
    @(negedge clk); chk_reset_vals("rst");
    tick();
    model_restart(32'h100);
    rst_n = 1;
    @(negedge clk); chk("lat_c0", 32'(instr_valid), 0);
    tick(); @(negedge clk); chk("lat_c1", 32'(instr_valid), 0);
    tick(); @(negedge clk); chk("lat_c2", 32'(instr_valid), 1); chk("lat_pc", instr_pc, 32'h100);
    repeat (10) tick();
    // Randomized ready/redirect traffic
    for (int i = 0; i < 400; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        t = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
        t[1:0] = 2'b00;
`endif
        redirect(t);
      end else tick();
    end
    // Fill the FIFO, then reset asynchronously mid-cycle
    instr_ready = 0;
    repeat (6) tick();
    @(negedge clk); chk("full_valid", 32'(instr_valid), 1);
    #2 rst_n = 0;
    #1 chk_reset_vals("arst");
    tick(); tick();
    model_restart(32'h100);
    rst_n = 1;
    // Back-pressure from cycle 2 for five cycles
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        chk("stall_valid", 32'(instr_valid), 1);
        chk("stall_pc", instr_pc, 32'h100);
        chk("stall_data", instr_data, 32'h100);
        chk("stall_addr", imem_addr, 32'h108);
      end
      tick();
    end
    instr_ready = 1;
    repeat (8) tick();
    // Redirect while popping with count=1 and one in flight
    redirect(32'h40);
    @(negedge clk); chk("rd_r1_valid", 32'(instr_valid), 0); chk("rd_r1_addr", imem_addr, 32'h40);
    tick(); @(negedge clk); chk("rd_r2_valid", 32'(instr_valid), 0);
    tick(); @(negedge clk); chk("rd_r3_valid", 32'(instr_valid), 1); chk("rd_r3_pc", instr_pc, 32'h40);
    repeat (4) tick();
    // PC wrap-around
    redirect(32'hFFFF_FFF8);
    repeat (2) tick();
    @(negedge clk); chk("wrap_pc0", instr_pc, 32'hFFFF_FFF8);
    tick(); @(negedge clk); chk("wrap_pc1", instr_pc, 32'hFFFF_FFFC);
    tick(); @(negedge clk); chk("wrap_pc2", instr_pc, 32'h0000_0000);
    repeat (3) tick();
    // Misaligned redirect
    redirect(32'h42);
`ifdef FETCH_MISALIGN_CHECK_EN
    @(negedge clk); chk("mis_set", 32'(misaligned), 1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); chk("mis_no_valid", 32'(instr_valid), 0);
      tick();
    end
    redirect(32'h80);
    @(negedge clk); chk("mis_clear", 32'(misaligned), 0);
    tick(); tick();
    @(negedge clk); chk("mis_r3_valid", 32'(instr_valid), 1); chk("mis_r3_pc", instr_pc, 32'h80);
`else
    @(negedge clk); chk("mis_tied", 32'(misaligned), 0); chk("mis_addr", imem_addr, 32'h40);
    tick(); tick();
    @(negedge clk); chk("mis_r3_valid", 32'(instr_valid), 1); chk("mis_r3_pc", instr_pc, 32'h40);
`endif
    repeat (10) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
